lru_replace_param: RTL
======================

Name: lru_replace_param

Overview:
- Parametrised successor to the fixed 16-set/4-way LRU replacement tracker.
- Keeps true-LRU age state per set for any power-of-two set and way count.
- Valid-way tracking: empty ways are filled before any valid way is evicted.
- Outputs the victim for one queried set through a registered read port, replacing the old one-port-per-line outputs; sits beside the cache tag array.

Parameters:
- WAY_NUM, 4, associativity; power of two, >= 2.
- SET_NUM, 16, number of sets; power of two, >= 2.
- INDEX_WIDTH, $clog2(SET_NUM), set index width.
- WAY_WIDTH, $clog2(WAY_NUM), encoded way width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- hit_en  input  WAY_NUM  one-hot hit vector; all-zero means no hit.
- hit_index  input  INDEX_WIDTH  set of the hit.
- fill_en  input  1  refill of a line completes this cycle.
- fill_index  input  INDEX_WIDTH  set being refilled.
- fill_way  input  WAY_WIDTH  way being refilled.
- inval_en  input  1  invalidate one line.
- inval_index  input  INDEX_WIDTH  set to invalidate.
- inval_way  input  WAY_WIDTH  way to invalidate.
- query_index  input  INDEX_WIDTH  set whose victim is requested.
- replace_way  output  WAY_WIDTH  victim way for the query issued in the previous cycle.
- replace_from_invalid  output  1  victim is an invalid way.
- hit_err  output  1  one-cycle pulse when hit_en has more than one bit set.

Behaviour:
- State per set:
  - age[w] is WAY_WIDTH bits; 0 = MRU, WAY_NUM-1 = LRU. Ages within a set are always a permutation of 0..WAY_NUM-1.
  - valid[w] is 1 bit.
- Reset (async, rst_n low):
  - age[w] = WAY_NUM-1-w in every set, so way0 is LRU.
  - All valid bits = 0.
  - replace_way = 0, replace_from_invalid = 1, hit_err = 0.
- Touch(set, way w), applied at posedge:
  - Every way v with age[v] < age[w] increments its age.
  - age[w] becomes 0.
  - All other ages are unchanged.
- Hit:
  - hit_en one-hot: touch(hit_index, onehot2bin(hit_en)). Valid bits are not changed.
  - hit_en zero: no action.
  - hit_en has two or more bits set: no state change, hit_err = 1 next cycle.
- Fill: touch(fill_index, fill_way) and set valid = 1.
- Invalidate: clear valid only; the age is unchanged.
- Simultaneous events on the same set:
  - fill beats hit: the hit update is dropped.
  - fill beats inval on the same way: the line ends valid.
  - inval on another way of the same set applies alongside the fill or hit.
- Events on different sets all apply in the same cycle.
- Victim selection (combinational on the current state of query_index, then registered; 1-cycle latency):
  - If any way is invalid: the lowest-index invalid way, with replace_from_invalid = 1.
  - Otherwise: the way with age == WAY_NUM-1, with replace_from_invalid = 0.
- No forwarding: a query in the same cycle as an update to that set sees the pre-update state.
- The query port has no enable; replace_way updates every cycle.

Optional Feature:
- Macro: LRU_WAY_LOCK_EN.
- Defined:
  - Adds input lock_mask [WAY_NUM-1:0]; a set bit excludes that way from victim selection in all sets.
  - Invalid unlocked ways are preferred first, then the oldest unlocked valid way.
  - If every way is locked, the normal unlocked rule applies and output lock_all = 1 for that result.
  - Locking never alters ages.
- Undefined: lock_mask and lock_all are absent; behaviour is exactly as above.

Test Plan:
- Reset, then query set3 -> replace_way = 0, replace_from_invalid = 1. All sets return the same result.
- Fill set0 ways 0,1,2,3 in order, then query set0 -> replace_way = 0, replace_from_invalid = 0.
- Continuing from the previous case: hit way0, query -> 1. Then hit way1, hit way2, query -> 3. Set1 still reports 0 with replace_from_invalid = 1.
- Fill all ways of set5, inval set5 way2, query -> 2 with replace_from_invalid = 1. Then fill set5 way2 and hit set5 way2 in the same cycle -> valid, single touch, ages remain a permutation.
- hit_en = 4'b0110 on set7 -> hit_err pulses 1 for one cycle and set7 ages are unchanged. Then pull rst_n low mid-sequence -> all outputs and state return to reset values immediately.
- With LRU_WAY_LOCK_EN, fully fill set2 with way0 LRU and lock_mask = 4'b0001 -> victim = the next-oldest way. lock_mask = 4'b1111 -> victim = 0 and lock_all = 1.

Source files
------------

// File: rtl/lru_replace_param.sv
// True-LRU replacement tracker for SET_NUM sets x WAY_NUM ways with valid-way priority.
// Optional macro LRU_WAY_LOCK_EN adds lock_mask/lock_all for victim exclusion.
module lru_replace_param #(
   parameter int WAY_NUM     = 4,
   parameter int SET_NUM     = 16,
   parameter int INDEX_WIDTH = $clog2(SET_NUM),
   parameter int WAY_WIDTH   = $clog2(WAY_NUM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WAY_NUM-1:0]     hit_en,
   input  logic [INDEX_WIDTH-1:0] hit_index,
   input  logic                   fill_en,
   input  logic [INDEX_WIDTH-1:0] fill_index,
   input  logic [WAY_WIDTH-1:0]   fill_way,
   input  logic                   inval_en,
   input  logic [INDEX_WIDTH-1:0] inval_index,
   input  logic [WAY_WIDTH-1:0]   inval_way,
   input  logic [INDEX_WIDTH-1:0] query_index,
`ifdef LRU_WAY_LOCK_EN
   input  logic [WAY_NUM-1:0]     lock_mask,
   output logic                   lock_all,
`endif
   output logic [WAY_WIDTH-1:0]   replace_way,
   output logic                   replace_from_invalid,
   output logic                   hit_err
);

   logic [SET_NUM-1:0][WAY_NUM-1:0][WAY_WIDTH-1:0] age_all;
   logic [SET_NUM-1:0][WAY_NUM-1:0]                valid_all;

   logic                 hit_multi;
   logic                 hit_valid;
   logic [WAY_WIDTH-1:0] hit_way;

   // A multi-bit hit vector is treated as an error and causes no state change.
   always_comb begin
      hit_multi = (hit_en & (hit_en - WAY_NUM'(1))) != '0;
      hit_valid = (hit_en != '0) && !hit_multi;
      hit_way   = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         if (hit_en[w]) hit_way = hit_way | WAY_WIDTH'(w);
      end
   end

   for (genvar gi = 0; gi < SET_NUM; gi++) begin : g_set
      logic [WAY_NUM-1:0][WAY_WIDTH-1:0] age_reg, age_next;
      logic [WAY_NUM-1:0]                valid_reg, valid_next;
      logic                              fill_here, hit_here, inval_here, touch;
      logic [WAY_WIDTH-1:0]              touch_way, touch_age;

      always_comb begin
         fill_here  = fill_en && (fill_index == INDEX_WIDTH'(gi));
         hit_here   = hit_valid && (hit_index == INDEX_WIDTH'(gi)) && !fill_here;
         inval_here = inval_en && (inval_index == INDEX_WIDTH'(gi));
         touch      = fill_here || hit_here;
         touch_way  = fill_here ? fill_way : hit_way;
         touch_age  = age_reg[touch_way];
         age_next   = age_reg;
         valid_next = valid_reg;
         if (touch) begin
            for (int w = 0; w < WAY_NUM; w++) begin
               if (WAY_WIDTH'(w) == touch_way)
                  age_next[w] = '0;
               else if (age_reg[w] < touch_age)
                  age_next[w] = age_reg[w] + WAY_WIDTH'(1);
            end
         end
         // Fill is applied after inval so a same-way collision leaves the line valid.
         if (inval_here) valid_next[inval_way] = 1'b0;
         if (fill_here)  valid_next[fill_way]  = 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int w = 0; w < WAY_NUM; w++) age_reg[w] <= WAY_WIDTH'(WAY_NUM - 1 - w);
            valid_reg <= '0;
         end else begin
            age_reg   <= age_next;
            valid_reg <= valid_next;
         end
      end

      assign age_all[gi]   = age_reg;
      assign valid_all[gi] = valid_reg;
   end

   logic [WAY_NUM-1:0][WAY_WIDTH-1:0] q_age;
   logic [WAY_NUM-1:0]                q_valid;
   logic [WAY_NUM-1:0]                excl;
   logic [WAY_WIDTH-1:0]              vict_way, best_age;
   logic                              vict_inv, found;
`ifdef LRU_WAY_LOCK_EN
   logic                              all_locked;
`endif

   always_comb begin
      q_age    = age_all[query_index];
      q_valid  = valid_all[query_index];
      excl     = '0;
`ifdef LRU_WAY_LOCK_EN
      // With every way locked the lock is ignored and flagged instead.
      all_locked = &lock_mask;
      excl       = all_locked ? '0 : lock_mask;
`endif
      vict_way = '0;
      vict_inv = 1'b0;
      found    = 1'b0;
      best_age = '0;
      for (int w = WAY_NUM - 1; w >= 0; w--) begin
         if (!q_valid[w] && !excl[w]) begin
            vict_way = WAY_WIDTH'(w);
            vict_inv = 1'b1;
         end
      end
      if (!vict_inv) begin
         for (int w = 0; w < WAY_NUM; w++) begin
            if (!excl[w] && (!found || q_age[w] > best_age)) begin
               found    = 1'b1;
               best_age = q_age[w];
               vict_way = WAY_WIDTH'(w);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         replace_way          <= '0;
         replace_from_invalid <= 1'b1;
         hit_err              <= 1'b0;
`ifdef LRU_WAY_LOCK_EN
         lock_all             <= 1'b0;
`endif
      end else begin
         replace_way          <= vict_way;
         replace_from_invalid <= vict_inv;
         hit_err              <= hit_multi;
`ifdef LRU_WAY_LOCK_EN
         lock_all             <= all_locked;
`endif
      end
   end

endmodule
